min3_sequencer: RTL
===================

# min3_sequencer

Sequencer for a three-channel acquisition path with one shared two-input minimum unit. It starts three converters with a common `soc`/`eoc` handshake and captures their samples. It computes the minimum serially over two cycles through a single comparator, then delivers the result to a consumer with a `dav_`/`rfd` handshake. It replaces a combinational three-way minimum, trading two cycles of latency for one shared comparator.

## Interface
Parameters:
- `W`, default 8: sample and result width.
- `TIMEOUT_CYCLES`, default 255: conversion watchdog limit. Used only when `MIN3_SEQ_TIMEOUT_EN` is defined.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `soc`  out  1  start of conversion, common to all three converters.
- `eoc1`, `eoc2`, `eoc3`  in  1  end of conversion, one per converter.
- `x1`, `x2`, `x3`  in  W  converter samples; valid while the corresponding `eoc` is 1.
- `dav_`  out  1  data available, active-low.
- `rfd`  in  1  consumer ready for data.
- `min`  out  W  registered minimum.
- `err`  out  1  sticky watchdog flag; constant 0 without the macro.

## Operation
- Reset values: `soc`=0, `dav_`=1, `min`=0, `err`=0. Sample registers X1–X3 and accumulator ACC are 0. State is S_START.
- The FSM has six states. Outputs and registers are loaded on the same edge as the transition.
- S_START: load `soc`=1. Leave to S_WAIT only when `soc` is already 1 and `eoc1`=`eoc2`=`eoc3`=0. On that edge, load `soc`=0.
- S_WAIT: when all three `eoc` are 1, latch X1←`x1`, X2←`x2`, X3←`x3`, then go to S_CMP1. Partial `eoc` patterns keep the state.
- S_CMP1: ACC ← (X1<X2) ? X1 : X2, then go to S_CMP2.
- S_CMP2: `min` ← (ACC<X3) ? ACC : X3, `dav_`←0, then go to S_OUT.
- S_OUT: when `rfd`=0, load `dav_`=1 and go to S_ACK.
- S_ACK: when `rfd`=1, go to S_START.
- Arithmetic:
  - Comparison is unsigned and strict, computed as the borrow of an W-bit subtraction.
  - Ties select the second operand; the value is identical either way.
  - No width growth.
- The comparator is instantiated once. It is muxed between (X1, X2) in S_CMP1 and (ACC, X3) in S_CMP2.
- `min` holds its value outside S_CMP2, including across a new conversion.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - Any in-flight conversion or handshake is abandoned.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `soc` rises on the first edge after reset release, and at the first edge in S_START after each completed cycle.
- Latency: all `eoc`=1 sampled at edge k → `min` valid and `dav_`=0 after edge k+2.
- `min` is stable from the fall of `dav_` until the next S_CMP2.
- Minimum full cycle is 7 clocks, with immediately responding converters and consumer.
- If `rfd` is already 0 on entry to S_OUT, `dav_` is still low for exactly one cycle.

## Configuration
- `MIN3_SEQ_TIMEOUT_EN` defined:
  - A counter clears on every state entry and increments each cycle spent in S_START or S_WAIT.
  - Reaching `TIMEOUT_CYCLES` sets `err`=1, loads `soc`=0 and returns to S_START, which re-issues `soc` on the next edge.
  - `err` clears only on reset.
  - S_OUT and S_ACK are never timed out.
- Undefined: no counter; `err` is tied to 0; S_START and S_WAIT wait indefinitely.

## Structure
- Shared package `min3_seq_pkg` holds the state enum (S_START, S_WAIT, S_CMP1, S_CMP2, S_OUT, S_ACK) and the default constants for `W` and `TIMEOUT_CYCLES`.
- One sub-module, `min2_unit`: a W-bit borrow compare plus select, purely combinational. It is instantiated once.

## Test plan
- Reset, then converters respond (`eoc` 1→0 two cycles after `soc`, →1 five cycles later) with x1=0x40, x2=0x15, x3=0x80 → `min`=0x15 and `dav_`=0 at edge k+2.
- x1=x2=x3=0xFF → `min`=0xFF. Then x1=0x00, x2=0xFF, x3=0x01 → `min`=0x00.
- Consumer holds `rfd`=1 for 10 cycles after `dav_` falls → `dav_` stays 0 and `min` stable. `rfd` 0 then 1 → `soc` re-rises one edge after S_ACK exits.
- `eoc3` stays 0 while `eoc1`/`eoc2` are 1 → no capture. When `eoc3` rises → capture on that edge.
- `reset_` pulsed low during S_CMP1 → `soc`=0, `dav_`=1, `min`=0 immediately, with no edge needed. Normal cycle resumes after release.
- With `MIN3_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `eoc` stuck at 1 → `err`=1 after 16 cycles in S_START, then `soc` toggles 0→1. Without the macro → `err` stays 0 and `soc` stays 1.

Source files
------------

// File: rtl/min3_seq_pkg.sv
// Shared definitions for the three-channel minimum sequencer: the state
// enumeration and the default parameter values.
package min3_seq_pkg;

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_WAIT  = 3'd1,
    S_CMP1  = 3'd2,
    S_CMP2  = 3'd3,
    S_OUT   = 3'd4,
    S_ACK   = 3'd5
  } state_e;

  localparam int MIN3_W_DEFAULT       = 8;
  localparam int MIN3_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/min2_unit.sv
// min2_unit: W-bit unsigned two-input minimum. The strict a<b decision is the
// borrow out of a - b; on a tie the second operand is returned.
module min2_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  logic         borrow;
  logic [W-1:0] unused_diff;

  // Only the borrow matters; the difference bits themselves are discarded.
  assign {borrow, unused_diff} = {1'b0, a_i} - {1'b0, b_i};
  assign y_o = borrow ? a_i : b_i;

endmodule

// File: rtl/min3_sequencer.sv
// min3_sequencer: starts three converters with a common soc, waits for all
// three eoc, captures the samples and computes their minimum over two cycles
// through one shared min2_unit, then offers the result to a consumer.
// Optional conversion watchdog: define MIN3_SEQ_TIMEOUT_EN.
//
// Consumer handshake: dav_ (active-low) falls together with a new min and
// stays low until the consumer drives rfd=0; dav_ then rises, and the next
// conversion starts only after rfd has returned to 1. min is valid whenever
// dav_ is low and holds until the next result is computed.
module min3_sequencer
  import min3_seq_pkg::*;
#(
  parameter int W              = MIN3_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = MIN3_TIMEOUT_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_,
  output logic         soc,
  input  logic         eoc1,
  input  logic         eoc2,
  input  logic         eoc3,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  output logic         dav_,
  input  logic         rfd,
  output logic [W-1:0] min,
  output logic         err,
  output state_e       dbg_state
);

  state_e       state_q;
  logic         soc_q;
  logic         dav_n_q;
  logic [W-1:0] x1_q, x2_q, x3_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] min_q;
  logic [W-1:0] cmp_a, cmp_b, cmp_y;
  logic         eoc_all, eoc_none;

  assign eoc_all  = eoc1 & eoc2 & eoc3;
  assign eoc_none = ~(eoc1 | eoc2 | eoc3);

  // Steer the shared comparator: (X1, X2) in the first compare step,
  // (ACC, X3) otherwise; only S_CMP1 and S_CMP2 consume its result.
  always_comb begin
    cmp_a = acc_q;
    cmp_b = x3_q;
    if (state_q == S_CMP1) begin
      cmp_a = x1_q;
      cmp_b = x2_q;
    end
  end

  min2_unit #(.W(W)) u_min2 (
    .a_i (cmp_a),
    .b_i (cmp_b),
    .y_o (cmp_y)
  );

`ifdef MIN3_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             idle_st;
  logic             idle_exit;

  // Only the two waiting states are watched; leaving them clears the count.
  assign idle_st   = (state_q == S_START) || (state_q == S_WAIT);
  assign idle_exit = ((state_q == S_START) && soc_q && eoc_none) ||
                     ((state_q == S_WAIT) && eoc_all);
  assign err       = err_q;
`else
  // The watchdog parameter stays referenced when the counter is compiled out.
  logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] unused_timeout;
  assign unused_timeout = '0;
  assign err            = 1'b0;
`endif

  // Sequencer FSM; every output and datapath register is loaded on the
  // same edge as the state transition that produces it.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_START;
      soc_q   <= 1'b0;
      dav_n_q <= 1'b1;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      acc_q   <= '0;
      min_q   <= '0;
`ifdef MIN3_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_START: begin
          // soc must have been seen high with all converters idle.
          if (soc_q && eoc_none) begin
            soc_q   <= 1'b0;
            state_q <= S_WAIT;
          end else begin
            soc_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (eoc_all) begin
            x1_q    <= x1;
            x2_q    <= x2;
            x3_q    <= x3;
            state_q <= S_CMP1;
          end
        end
        S_CMP1: begin
          acc_q   <= cmp_y;
          state_q <= S_CMP2;
        end
        S_CMP2: begin
          min_q   <= cmp_y;
          dav_n_q <= 1'b0;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (!rfd) begin
            dav_n_q <= 1'b1;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          if (rfd) begin
            state_q <= S_START;
          end
        end
        default: begin
          state_q <= S_START;
        end
      endcase
`ifdef MIN3_SEQ_TIMEOUT_EN
      // Watchdog overrides the stay-put decision of the waiting states.
      if (idle_st && !idle_exit) begin
        if (cnt_q == CNT_LAST) begin
          err_q   <= 1'b1;
          soc_q   <= 1'b0;
          state_q <= S_START;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
`endif
    end
  end

  assign soc       = soc_q;
  assign dav_      = dav_n_q;
  assign min       = min_q;
  assign dbg_state = state_q;

endmodule
